// File: rtl/cirno_fetch_pkg.sv
// Shared types and defaults for the cirno instruction-fetch stage.
package cirno_fetch_pkg;

    localparam int unsigned IW_DEF   = 9;
    localparam int unsigned AW_DEF   = 9;
    localparam int unsigned OFFW_DEF = 6;
    localparam logic [8:0]  HALT_OP_DEF = 9'h001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Sign-extend the low w bits of val to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned w);
        int unsigned sh;
        sh = 32 - w;
        return 32'($signed(val << sh) >>> sh);
    endfunction

endpackage

// File: rtl/fetch_unit_pipe_if.sv
// Decode handshake and program-loader bus of the fetch stage.
interface fetch_unit_pipe_if #(
    parameter int unsigned IW = 9,
    parameter int unsigned AW = 9
);
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;

    // Fetch unit side.
    modport master (
        output inst_valid, inst, inst_pc,
        input  inst_ready, load_en, load_addr, load_data
    );

    // Decode / loader side.
    modport slave (
        input  inst_valid, inst, inst_pc,
        output inst_ready, load_en, load_addr, load_data
    );
endinterface

// File: rtl/fetch_unit_pipe_prog_mem.sv
// Program memory: one sync write port, one sync read port with read enable.
module prog_mem #(
    parameter int unsigned AW = 9,
    parameter int unsigned IW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [IW-1:0] r_mem [DEPTH];

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register doubles as the instruction output; it holds while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end
endmodule

// File: rtl/fetch_unit_pipe.sv
// Instruction-fetch stage: PC, redirects, stall, halt detection, decode handshake.
module fetch_unit_pipe
    import cirno_fetch_pkg::*;
#(
    parameter int unsigned   IW      = IW_DEF,
    parameter int unsigned   AW      = AW_DEF,
    parameter int unsigned   OFFW    = OFFW_DEF,
    parameter logic [IW-1:0] HALT_OP = IW'(HALT_OP_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic             branch,
    input  logic [AW-1:0]    target,
    input  logic             branchi,
    input  logic [OFFW-1:0]  offset,
    output logic             busy,
    output logic             halted,
    fetch_unit_pipe_if.master bus
);
    fetch_state_t  r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [AW-1:0] r_inst_pc, w_inst_pc_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_busy, r_halted;
    logic          w_rd_en;
    logic          w_we;
    logic          w_accept;
    logic [IW-1:0] w_inst;
    logic [AW-1:0] w_rel_pc;

    assign w_accept = r_valid && bus.inst_ready;
    assign w_rel_pc = r_inst_pc + AW'(sext(32'(offset), OFFW));
    assign w_we     = bus.load_en && (r_state != RUN);

    prog_mem #(.AW(AW), .IW(IW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_data),
        .i_re    (w_rd_en),
        .i_raddr (r_pc),
        .o_rdata (w_inst)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next PC and fetch issue; a redirect drops the current inst (one bubble).
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_pc_nxt = r_inst_pc;
        w_valid_nxt   = r_valid;
        w_rd_en       = 1'b0;
        case (r_state)
            IDLE, HALTED: begin
                w_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = start_addr;
                end
            end
            RUN: begin
                if (start) begin
                    w_pc_nxt    = start_addr;
                    w_valid_nxt = 1'b0;
                end else if (branch) begin
                    w_pc_nxt    = target;
                    w_valid_nxt = 1'b0;
                end else if (branchi && r_valid) begin
                    w_pc_nxt    = w_rel_pc;
                    w_valid_nxt = 1'b0;
                end else if (w_accept && (w_inst == HALT_OP)) begin
                    w_state_nxt = HALTED;
                    w_valid_nxt = 1'b0;
                end else if (!r_valid || bus.inst_ready) begin
                    w_rd_en       = 1'b1;
                    w_pc_nxt      = r_pc + AW'(1);
                    w_inst_pc_nxt = r_pc;
                    w_valid_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // PC, output qualifiers and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= (w_state_nxt == RUN);
            r_halted  <= (w_state_nxt == HALTED);
        end
    end

    assign bus.inst_valid = r_valid;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst       = w_inst;
    assign busy           = r_busy;
    assign halted         = r_halted;
endmodule

// File: tb/tb_fetch_unit_pipe.sv
// Directed self-checking bench for fetch_unit_pipe.
module tb_fetch_unit_pipe;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] start_addr;
    logic       branch;
    logic [8:0] target;
    logic       branchi;
    logic [5:0] offset;
    logic       busy;
    logic       halted;
    int         checks = 0;
    int         errors = 0;

    fetch_unit_pipe_if #(.IW(9), .AW(9)) bus ();

    fetch_unit_pipe #(.IW(9), .AW(9), .OFFW(6), .HALT_OP(9'h001)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .branch     (branch),
        .target     (target),
        .branchi    (branchi),
        .offset     (offset),
        .busy       (busy),
        .halted     (halted),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [8:0] a, input logic [8:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; start_addr = '0; branch = 0; target = '0;
        branchi = 0; offset = '0; bus.inst_ready = 0;
        bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== 19'h0) begin errors++; $display("FAIL reset_outputs: got v=%b pc=%h inst=%h exp all zero", bus.inst_valid, bus.inst_pc, bus.inst); end
        checks++; if ({busy, halted} !== 2'b00) begin errors++; $display("FAIL reset_status: got busy=%b halted=%b exp 0 0", busy, halted); end
        rst_n = 1'b1;
        tick();
        checks++; if ({bus.inst_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got v=%b busy=%b exp 0 0", bus.inst_valid, busy); end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 512; i++) load_word(9'(i), 9'(i) | 9'h100);
    endtask

    task automatic test_program();
        load_word(9'h000, 9'h0A5);
        load_word(9'h001, 9'h05A);
        load_word(9'h002, 9'h001);
        bus.inst_ready = 1'b1;
        start = 1'b1; start_addr = 9'h000;
        tick();
        start = 1'b0;
        checks++; if ({bus.inst_valid, busy} !== 2'b01) begin errors++; $display("FAIL prog_bubble: got v=%b busy=%b exp 0 1", bus.inst_valid, busy); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h000, 9'h0A5}) begin errors++; $display("FAIL prog_i0: got v=%b pc=%h inst=%h exp 1 000 0a5", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h001, 9'h05A}) begin errors++; $display("FAIL prog_i1: got v=%b pc=%h inst=%h exp 1 001 05a", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h002, 9'h001}) begin errors++; $display("FAIL prog_i2: got v=%b pc=%h inst=%h exp 1 002 001", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, busy, halted} !== 3'b001) begin errors++; $display("FAIL prog_halt: got v=%b busy=%b halted=%b exp 0 0 1", bus.inst_valid, busy, halted); end
        branch = 1'b1; target = 9'h040;
        tick();
        branch = 1'b0;
        tick();
        checks++; if ({bus.inst_valid, busy, halted} !== 3'b001) begin errors++; $display("FAIL halted_ignores_branch: got v=%b busy=%b halted=%b exp 0 0 1", bus.inst_valid, busy, halted); end
    endtask

    task automatic test_stall();
        load_word(9'h000, 9'h100);
        load_word(9'h001, 9'h101);
        load_word(9'h002, 9'h102);
        start = 1'b1; start_addr = 9'h000;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h002, 9'h102}) begin errors++; $display("FAIL stall_pre: got v=%b pc=%h inst=%h exp 1 002 102", bus.inst_valid, bus.inst_pc, bus.inst); end
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h002, 9'h102}) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h exp 1 002 102", i, bus.inst_valid, bus.inst_pc, bus.inst); end
        end
        bus.inst_ready = 1'b1;
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h003, 9'h103}) begin errors++; $display("FAIL stall_pc3: got v=%b pc=%h inst=%h exp 1 003 103", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h004, 9'h104}) begin errors++; $display("FAIL stall_pc4: got v=%b pc=%h inst=%h exp 1 004 104", bus.inst_valid, bus.inst_pc, bus.inst); end
    endtask

    task automatic test_branch();
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.inst_valid === 1'b1 && bus.inst_pc === 9'h005) found = 1'b1;
            else tick();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL branch_wait_pc5: got found=%b exp 1", found); end
        bus.inst_ready = 1'b0;
        branch = 1'b1; target = 9'h040;
        tick();
        branch = 1'b0;
        bus.inst_ready = 1'b1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble: got v=%b exp 0", bus.inst_valid); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h040, 9'h140}) begin errors++; $display("FAIL branch_target: got v=%b pc=%h inst=%h exp 1 040 140", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h041, 9'h141}) begin errors++; $display("FAIL branch_next: got v=%b pc=%h inst=%h exp 1 041 141", bus.inst_valid, bus.inst_pc, bus.inst); end
    endtask

    task automatic test_branchi();
        branch = 1'b1; target = 9'h010;
        tick();
        branch = 1'b0;
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 9'h010}) begin errors++; $display("FAIL bri_setup: got v=%b pc=%h exp 1 010", bus.inst_valid, bus.inst_pc); end
        branchi = 1'b1; offset = 6'b111100;
        tick();
        branchi = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL bri_bubble: got v=%b exp 0", bus.inst_valid); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h00C, 9'h10C}) begin errors++; $display("FAIL bri_neg: got v=%b pc=%h inst=%h exp 1 00c 10c", bus.inst_valid, bus.inst_pc, bus.inst); end
        branch = 1'b1; target = 9'h1FF;
        tick();
        branch = 1'b0;
        branchi = 1'b1; offset = 6'd3;
        tick();
        branchi = 1'b0;
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h1FF, 9'h1FF}) begin errors++; $display("FAIL bri_ignored_invalid: got v=%b pc=%h inst=%h exp 1 1ff 1ff", bus.inst_valid, bus.inst_pc, bus.inst); end
        branchi = 1'b1; offset = 6'd3;
        tick();
        branchi = 1'b0;
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h002, 9'h102}) begin errors++; $display("FAIL bri_wrap: got v=%b pc=%h inst=%h exp 1 002 102", bus.inst_valid, bus.inst_pc, bus.inst); end
    endtask

    task automatic test_wrap();
        start = 1'b1; start_addr = 9'h1FE;
        branch = 1'b1; target = 9'h040;
        bus.load_en = 1'b1; bus.load_addr = 9'h001; bus.load_data = 9'h0AA;
        tick();
        start = 1'b0; branch = 1'b0;
        checks++; if ({bus.inst_valid, busy} !== 2'b01) begin errors++; $display("FAIL wrap_bubble: got v=%b busy=%b exp 0 1", bus.inst_valid, busy); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h1FE, 9'h1FE}) begin errors++; $display("FAIL wrap_1fe: got v=%b pc=%h inst=%h exp 1 1fe 1fe", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h1FF, 9'h1FF}) begin errors++; $display("FAIL wrap_1ff: got v=%b pc=%h inst=%h exp 1 1ff 1ff", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h000, 9'h100}) begin errors++; $display("FAIL wrap_000: got v=%b pc=%h inst=%h exp 1 000 100", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h001, 9'h101}) begin errors++; $display("FAIL run_load_ignored: got v=%b pc=%h inst=%h exp 1 001 101", bus.inst_valid, bus.inst_pc, bus.inst); end
        bus.load_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.inst_valid, busy, halted, bus.inst_pc, bus.inst} !== 21'h0) begin errors++; $display("FAIL rst_async: got v=%b busy=%b halted=%b pc=%h inst=%h exp all zero", bus.inst_valid, busy, halted, bus.inst_pc, bus.inst); end
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if ({bus.inst_valid, busy, halted} !== 3'b000) begin errors++; $display("FAIL rst_stays_idle: got v=%b busy=%b halted=%b exp 0 0 0", bus.inst_valid, busy, halted); end
        start = 1'b1; start_addr = 9'h000;
        tick();
        start = 1'b0;
        tick();
        checks++; if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 9'h000, 9'h100}) begin errors++; $display("FAIL rst_mem_kept: got v=%b pc=%h inst=%h exp 1 000 100", bus.inst_valid, bus.inst_pc, bus.inst); end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_program();
        test_stall();
        test_branch();
        test_branchi();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
